data_mem_bytelane: RTL and testbench
====================================

Name: data_mem_bytelane

Overview:
- Parametrised successor data memory for the MIPS pipeline MEM stage. Stores are byte-addressed (SB/SH/SW), loads are byte-addressed with sign or zero extension (LB/LBU/LH/LHU/LW).
- Configurable read latency; alignment fault flag.
- Hardware clear sequencer after reset.
- Handshaked debug read port for the Debug Unit, replacing fixed taps on words 0..3.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, >= 4.
- ADDR_W, 32, byte-address width of addr.
- READ_LAT, 1, load latency in cycles; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = skip the clear.
- IDX_W, clog2(DEPTH), derived word-index width.

Ports:
- clk, in, 1: clock; all logic acts on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- en, in, 1: access request this cycle.
- wr, in, 1: 1 = store, 0 = load; valid with en.
- addr, in, ADDR_W: byte address.
- size, in, 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- uns, in, 1: zero-extend loads (LBU/LHU).
- wdata, in, 32: store data, right-justified.
- rdata, out, 32: extended load result.
- rvalid, out, 1: rdata valid, one-cycle pulse.
- misalign, out, 1: alignment fault pulse.
- busy, out, 1: clear in progress; requests are ignored while high.
- dbg_req, in, 1: debug read request (level).
- dbg_addr, in, IDX_W: debug word index.
- dbg_ack, out, 1: debug data valid, one-cycle pulse.
- dbg_data, out, 32: raw debug word.

Behaviour:
- Reset values: rdata=0, rvalid=0, misalign=0, dbg_ack=0, dbg_data=0. Latency pipeline is flushed. busy=CLEAR_ON_RESET on the cycle after rst.
- State machine: CLEAR and READY.
  - rst goes to CLEAR (CLEAR_ON_RESET=1) or READY (CLEAR_ON_RESET=0).
  - CLEAR writes 0 to word clr_cnt each cycle, counting 0..DEPTH-1. After DEPTH cycles, moves to READY and busy drops.
  - rst asserted mid-clear restarts clr_cnt at 0.
- Word index = addr[IDX_W+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
- Alignment rule: half requires addr[0]=0; word requires addr[1:0]=00.
  - A violating en request does not modify memory and produces no rvalid.
  - misalign pulses exactly 1 cycle after the request, for both loads and stores.
- Stores (en & wr & aligned & READY) commit on that rising edge.
  - SB writes wdata[7:0] into lane addr[1:0].
  - SH writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - SW writes all 4 lanes. Other lanes are unchanged.
  - Little-endian lanes: lane 0 = bits 7:0.
- Loads (en & ~wr & aligned & READY) issued in cycle t produce rvalid=1 in cycle t+READ_LAT, with rdata:
  - byte: lane addr[1:0], extended from bit 7.
  - half: extended from bit 15.
  - word: raw.
  - uns=1 zero-extends; otherwise sign-extends.
  - rdata holds its value until the next rvalid.
- Back-to-back: one request per cycle with full throughput. A load in cycle t+1 after a store in cycle t to the same word returns the stored data.
- en during busy: ignored silently; no rvalid, no misalign.
- Debug port: independent read port, so there is no contention with the main port.
  - dbg_req sampled high while READY and dbg_ack=0 gives dbg_ack=1 and dbg_data=mem[dbg_addr] on the next cycle.
  - A held req yields an ack every other cycle.
  - Requests during busy are held off until READY.
  - A debug read in the same cycle as a store to the same word returns the old data.

Decomposition:
- Package data_mem_pkg holds:
  - size codes MEM_SZ_B=2'b00, MEM_SZ_H=2'b01, MEM_SZ_W=2'b10;
  - state encodings ST_CLEAR and ST_READY;
  - function align_ok(size, addr_lo).
- Sub-module data_mem_bram: DEPTH x 32 array with a 4-bit byte-write-enable port and two registered read ports (main, debug), inferable as BRAM.
- data_mem_bytelane holds the FSM, lane steering, extension and READ_LAT pipeline.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=256 -> busy high for exactly 256 cycles; afterwards, debug reads of words 0, 128 and 255 all return 0.
- SW 0x80FF7F01 @0x10, then LB @0x10, LB @0x11, LBU @0x11, LH @0x12, LHU @0x12 -> rdata 0x00000001, 0xFFFFFF7F... wait, lane1=0x7F gives LB @0x11=0x0000007F; expected sequence is 0x00000001, 0x0000007F, 0x0000007F, 0xFFFF80FF, 0x000080FF, each pulsing rvalid READ_LAT cycles after issue.
- SW 0xFFFFFFFF @0x20, SB 0xAB @0x22, SH 0x1234 @0x20, LW @0x20 -> 0xFFAB1234.
- LW @0x21, SH @0x23 -> misalign pulses 1 cycle after each request; no rvalid; word 8 unchanged.
- READ_LAT=2 run: issue LW @0,4,8 in consecutive cycles -> rvalid in cycles t+2, t+3, t+4 with the correct data; addr 4*DEPTH+4 aliases word 1.
- dbg_req held high during a burst of stores and a mid-clear rst -> acks only when READY, no lost main-port accesses, clear restarts from word 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared constants and helpers for the byte-lane data memory.
// Size codes, FSM encodings and the alignment rule used by the MEM-stage port.
package data_mem_pkg;

    localparam logic [1:0] MEM_SZ_B = 2'b00;
    localparam logic [1:0] MEM_SZ_H = 2'b01;
    localparam logic [1:0] MEM_SZ_W = 2'b10;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Size code 2'b11 falls into the word rule.
    function automatic logic align_ok(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            MEM_SZ_B: ok = 1'b1;
            MEM_SZ_H: ok = ~addr_lo[0];
            default:  ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_bram.sv
// DEPTH x 32 storage with per-byte write enables and two registered read ports.
// Read ports are read-first and hold their output until the next enabled read.
module data_mem_bram #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             a_re_i,
    input  logic [3:0]       a_we_i,
    input  logic [IDX_W-1:0] a_addr_i,
    input  logic [31:0]      a_wdata_i,
    output logic [31:0]      a_rdata_o,
    input  logic             b_re_i,
    input  logic [IDX_W-1:0] b_addr_i,
    output logic [31:0]      b_rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] a_rdata_q;
    logic [31:0] b_rdata_q;

    // Byte-lane writes on port A.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < 4; l++) begin
            if (a_we_i[l]) begin
                mem_q[a_addr_i][8*l +: 8] <= a_wdata_i[8*l +: 8];
            end
        end
    end

    // Port A read register; output register reset keeps it BRAM-mappable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_rdata_q <= 32'd0;
        end else if (a_re_i) begin
            a_rdata_q <= mem_q[a_addr_i];
        end
    end

    // Port B (debug) read register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            b_rdata_q <= 32'd0;
        end else if (b_re_i) begin
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/data_mem_bytelane.sv
// MEM-stage data memory: byte/half/word stores and extended loads, post-reset
// clear sequencer, alignment fault pulse and a handshaked debug read port.
module data_mem_bytelane
    import data_mem_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 32,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter int IDX_W          = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        size_i,
    input  logic              uns_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              rvalid_o,
    output logic              misalign_o,
    output logic              busy_o,
    input  logic              dbg_req_i,
    input  logic [IDX_W-1:0]  dbg_addr_i,
    output logic              dbg_ack_o,
    output logic [31:0]       dbg_data_o
);

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [1:0] sz, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            MEM_SZ_B: r = {{24{~u & b[7]}}, b};
            MEM_SZ_H: r = {{16{~u & h[15]}}, h};
            default:  r = w;
        endcase
        return r;
    endfunction

    logic [0:0]       state_q;
    logic [IDX_W-1:0] clr_cnt_q;
    logic             v1_q, v2_q, misalign_q, dbg_ack_q;
    logic [1:0]       lane1_q, size1_q;
    logic             uns1_q;
    logic [31:0]      rdata2_q;

    logic             ready_s, aligned_s, acc_s, st_fire_s, ld_fire_s, dbg_fire_s;
    logic [3:0]       we_s;
    logic [IDX_W-1:0] waddr_s;
    logic [31:0]      wdata_s, bram_rdata_s, ext_s;
    logic             unused_s;

    assign unused_s   = ^addr_i[ADDR_W-1:IDX_W+2];
    assign ready_s    = (state_q == ST_READY);
    assign aligned_s  = align_ok(size_i, addr_i[1:0]);
    assign acc_s      = en_i & ready_s & ~rst_i;
    assign st_fire_s  = acc_s & wr_i & aligned_s;
    assign ld_fire_s  = acc_s & ~wr_i & aligned_s;
    assign dbg_fire_s = dbg_req_i & ready_s & ~dbg_ack_q & ~rst_i;

    // Clear sequencer: one zeroed word per cycle, restarted by every reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            state_q   <= (clr_cnt_q == IDX_W'(DEPTH - 1)) ? ST_READY : ST_CLEAR;
        end else begin
            state_q   <= state_q;
            clr_cnt_q <= clr_cnt_q;
        end
    end

    // Lane steering: narrow store data is replicated so the byte enables pick the lane.
    always_comb begin
        we_s    = 4'b0000;
        waddr_s = addr_i[IDX_W+1:2];
        wdata_s = wdata_i;
        if (state_q == ST_CLEAR && !rst_i) begin
            we_s    = 4'b1111;
            waddr_s = clr_cnt_q;
            wdata_s = 32'd0;
        end else if (st_fire_s) begin
            case (size_i)
                MEM_SZ_B: begin
                    we_s    = 4'b0001 << addr_i[1:0];
                    wdata_s = {4{wdata_i[7:0]}};
                end
                MEM_SZ_H: begin
                    we_s    = addr_i[1] ? 4'b1100 : 4'b0011;
                    wdata_s = {2{wdata_i[15:0]}};
                end
                default: begin
                    we_s    = 4'b1111;
                    wdata_s = wdata_i;
                end
            endcase
        end else begin
            we_s = 4'b0000;
        end
    end

    data_mem_bram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_bram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .a_re_i    (ld_fire_s),
        .a_we_i    (we_s),
        .a_addr_i  (waddr_s),
        .a_wdata_i (wdata_s),
        .a_rdata_o (bram_rdata_s),
        .b_re_i    (dbg_fire_s),
        .b_addr_i  (dbg_addr_i),
        .b_rdata_o (dbg_data_o)
    );

    assign ext_s = load_ext(bram_rdata_s, lane1_q, size1_q, uns1_q);

    // Load metadata tracks the BRAM read so the extended value holds between loads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            lane1_q    <= 2'b00;
            size1_q    <= MEM_SZ_W;
            uns1_q     <= 1'b0;
            rdata2_q   <= 32'd0;
            misalign_q <= 1'b0;
            dbg_ack_q  <= 1'b0;
        end else begin
            v1_q       <= ld_fire_s;
            v2_q       <= v1_q;
            misalign_q <= acc_s & ~aligned_s;
            dbg_ack_q  <= dbg_fire_s;
            if (ld_fire_s) begin
                lane1_q <= addr_i[1:0];
                size1_q <= size_i;
                uns1_q  <= uns_i;
            end
            if (v1_q) begin
                rdata2_q <= ext_s;
            end
        end
    end

    assign rdata_o    = (READ_LAT == 2) ? rdata2_q : ext_s;
    assign rvalid_o   = (READ_LAT == 2) ? v2_q : v1_q;
    assign misalign_o = misalign_q;
    assign busy_o     = (state_q == ST_CLEAR);
    assign dbg_ack_o  = dbg_ack_q;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Directed bench: two instances (READ_LAT 1 and 2) share one stimulus stream.
module tb_data_mem_bytelane;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic        clk = 1'b0;
    logic        rst, en, wr, uns, dbg_req;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic [7:0]  dbg_addr;

    logic [31:0] rdata1, ddata1, rdata2, ddata2;
    logic        rvalid1, mis1, busy1, dack1;
    logic        rvalid2, mis2, busy2, dack2;

    int n_chk  = 0;
    int n_fail = 0;
    int n, acks;

    always #5 clk = ~clk;

    data_mem_bytelane #(.DEPTH(256), .ADDR_W(32), .READ_LAT(1), .CLEAR_ON_RESET(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .wr_i(wr), .addr_i(addr), .size_i(size),
        .uns_i(uns), .wdata_i(wdata), .rdata_o(rdata1), .rvalid_o(rvalid1),
        .misalign_o(mis1), .busy_o(busy1), .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr),
        .dbg_ack_o(dack1), .dbg_data_o(ddata1)
    );

    data_mem_bytelane #(.DEPTH(256), .ADDR_W(32), .READ_LAT(2), .CLEAR_ON_RESET(1)) u_lat2 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .wr_i(wr), .addr_i(addr), .size_i(size),
        .uns_i(uns), .wdata_i(wdata), .rdata_o(rdata2), .rvalid_o(rvalid2),
        .misalign_o(mis2), .busy_o(busy2), .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr),
        .dbg_ack_o(dack2), .dbg_data_o(ddata2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] d);
        en = 1'b1; wr = w; addr = a; size = s; uns = u; wdata = d;
        tick();
    endtask

    task automatic idle();
        en = 1'b0;
        tick();
    endtask

    task automatic load1(input string tag, input logic [31:0] a, input logic [1:0] s,
                         input logic u, input logic [31:0] exp);
        req(1'b0, a, s, u, 32'd0);
        check({tag, "_rv"}, {31'd0, rvalid1}, 32'd1);
        check(tag, rdata1, exp);
    endtask

    task automatic dbg_read(input string tag, input logic [7:0] idx, input logic [31:0] exp);
        int k;
        dbg_addr = idx;
        dbg_req  = 1'b1;
        k = 0;
        tick();
        while (!dack1 && k < 8) begin
            tick();
            k++;
        end
        dbg_req = 1'b0;
        check({tag, "_ack"}, {31'd0, dack1}, 32'd1);
        check(tag, ddata1, exp);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wr = 1'b0; uns = 1'b0; dbg_req = 1'b0;
        addr = 32'd0; wdata = 32'd0; size = SZ_W; dbg_addr = 8'd0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy1}, 32'd1);
        check("rst_rdata", rdata1, 32'd0);
        check("rst_rvalid", {31'd0, rvalid1}, 32'd0);
        check("rst_misalign", {31'd0, mis1}, 32'd0);
        check("rst_dbg_ack", {31'd0, dack1}, 32'd0);
        check("rst_dbg_data", ddata1, 32'd0);
        rst = 1'b0;

        // Misaligned load while busy: silently ignored.
        req(1'b0, 32'h21, SZ_W, 1'b0, 32'd0);
        en = 1'b0;
        check("busy_mis", {31'd0, mis1}, 32'd0);
        check("busy_rv", {31'd0, rvalid1}, 32'd0);
        n = 0;
        while (busy1 && n < 600) begin
            tick();
            n++;
        end
        check("clear_len", 32'(n + 1), 32'd256);
        check("clear_len_lat2", {31'd0, busy2}, 32'd0);
        dbg_read("clr_w0", 8'd0, 32'd0);
        dbg_read("clr_w128", 8'd128, 32'd0);
        dbg_read("clr_w255", 8'd255, 32'd0);

        // Lane extraction and extension, store immediately followed by loads.
        req(1'b1, 32'h10, SZ_W, 1'b0, 32'h80FF7F01);
        check("sw_rv", {31'd0, rvalid1}, 32'd0);
        check("sw_mis", {31'd0, mis1}, 32'd0);
        load1("lb_10", 32'h10, SZ_B, 1'b0, 32'h00000001);
        load1("lb_11", 32'h11, SZ_B, 1'b0, 32'h0000007F);
        load1("lbu_11", 32'h11, SZ_B, 1'b1, 32'h0000007F);
        load1("lh_12", 32'h12, SZ_H, 1'b0, 32'hFFFF80FF);
        load1("lhu_12", 32'h12, SZ_H, 1'b1, 32'h000080FF);
        load1("lb_13", 32'h13, SZ_B, 1'b0, 32'hFFFFFF80);
        load1("lbu_13", 32'h13, SZ_B, 1'b1, 32'h00000080);
        idle();
        check("hold_rv", {31'd0, rvalid1}, 32'd0);
        check("hold_rdata", rdata1, 32'h00000080);

        // Partial stores merge into an existing word.
        req(1'b1, 32'h20, SZ_W, 1'b0, 32'hFFFFFFFF);
        req(1'b1, 32'h22, SZ_B, 1'b0, 32'h000000AB);
        req(1'b1, 32'h20, SZ_H, 1'b0, 32'h00001234);
        load1("merge", 32'h20, SZ_W, 1'b0, 32'hFFAB1234);

        // Alignment faults.
        req(1'b0, 32'h21, SZ_W, 1'b0, 32'd0);
        check("mis_lw", {31'd0, mis1}, 32'd1);
        check("mis_lw_rv", {31'd0, rvalid1}, 32'd0);
        req(1'b1, 32'h23, SZ_H, 1'b0, 32'h00005555);
        check("mis_sh", {31'd0, mis1}, 32'd1);
        idle();
        check("mis_drop", {31'd0, mis1}, 32'd0);
        load1("mis_unchanged", 32'h20, SZ_W, 1'b0, 32'hFFAB1234);
        load1("size3_word", 32'h20, 2'b11, 1'b0, 32'hFFAB1234);

        // Debug read colliding with a store to the same word sees the old value.
        dbg_addr = 8'd8;
        dbg_req  = 1'b1;
        req(1'b1, 32'h20, SZ_W, 1'b0, 32'h11111111);
        dbg_req  = 1'b0;
        en       = 1'b0;
        check("dbg_col_ack", {31'd0, dack1}, 32'd1);
        check("dbg_col_old", ddata1, 32'hFFAB1234);
        tick();
        dbg_read("dbg_new", 8'd8, 32'h11111111);

        // READ_LAT=2 pipeline on consecutive loads.
        req(1'b1, 32'h0, SZ_W, 1'b0, 32'hA0A0A0A0);
        req(1'b1, 32'h4, SZ_W, 1'b0, 32'hB1B1B1B1);
        req(1'b1, 32'h8, SZ_W, 1'b0, 32'hC2C2C2C2);
        req(1'b0, 32'h0, SZ_W, 1'b0, 32'd0);
        check("l2_t1_rv", {31'd0, rvalid2}, 32'd0);
        req(1'b0, 32'h4, SZ_W, 1'b0, 32'd0);
        check("l2_t2_rv", {31'd0, rvalid2}, 32'd1);
        check("l2_t2", rdata2, 32'hA0A0A0A0);
        req(1'b0, 32'h8, SZ_W, 1'b0, 32'd0);
        check("l2_t3_rv", {31'd0, rvalid2}, 32'd1);
        check("l2_t3", rdata2, 32'hB1B1B1B1);
        idle();
        check("l2_t4_rv", {31'd0, rvalid2}, 32'd1);
        check("l2_t4", rdata2, 32'hC2C2C2C2);
        idle();
        check("l2_t5_rv", {31'd0, rvalid2}, 32'd0);
        check("l2_hold", rdata2, 32'hC2C2C2C2);
        load1("alias", 32'd1028, SZ_W, 1'b0, 32'hB1B1B1B1);

        // Held debug request during a store burst: ack every other cycle.
        idle();
        dbg_addr = 8'd1;
        dbg_req  = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            req(1'b1, 32'h40 + 32'(4 * i), SZ_W, 1'b0, 32'h1000 + 32'(i));
            acks += int'(dack1);
        end
        check("dbg_held_acks", 32'(acks), 32'd3);
        check("dbg_held_data", ddata1, 32'hB1B1B1B1);
        for (int i = 0; i < 6; i++) begin
            load1("burst_ld", 32'h40 + 32'(4 * i), SZ_W, 1'b0, 32'h1000 + 32'(i));
        end
        en = 1'b0;

        // Reset mid-clear with the debug request still held.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_rdata", rdata1, 32'd0);
        check("rst2_busy", {31'd0, busy1}, 32'd1);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            acks += int'(dack1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (busy1 && n < 600) begin
            acks += int'(dack1);
            tick();
            n++;
        end
        check("reclear_len", 32'(n), 32'd256);
        check("busy_acks", 32'(acks), 32'd0);
        n = 0;
        while (!dack1 && n < 4) begin
            tick();
            n++;
        end
        dbg_req = 1'b0;
        check("post_clr_ack", {31'd0, dack1}, 32'd1);
        check("post_clr_w1", ddata1, 32'd0);
        tick();
        load1("post_clr_ld", 32'h10, SZ_W, 1'b0, 32'd0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
